// File: rtl/keccak_pkg.sv
// Shared Keccak types and constants: hash modes, absorb sequencer states,
// domain-separation suffixes and the per-mode rate in 64-bit lanes.
package keccak_pkg;

  localparam int MODE_SEL_WIDTH = 2;

  typedef enum logic [1:0] {
    SHA3_256 = 2'd0,
    SHA3_512 = 2'd1,
    SHAKE128 = 2'd2,
    SHAKE256 = 2'd3
  } keccak_mode;

  typedef enum logic [2:0] {
    AB_IDLE = 3'd0,
    AB_LOAD = 3'd1,
    AB_EMIT = 3'd2,
    AB_PAD  = 3'd3,
    AB_DONE = 3'd4
  } absorb_state;

  localparam logic [7:0] SHA3_SUFFIX   = 8'h06;
  localparam logic [7:0] SHAKE_SUFFIX  = 8'h1F;
  localparam logic [7:0] PAD_LAST_BYTE = 8'h80;

  function automatic logic [4:0] rate_lanes(input keccak_mode mode);
    case (mode)
      SHA3_256: rate_lanes = 5'd17;
      SHA3_512: rate_lanes = 5'd9;
      SHAKE128: rate_lanes = 5'd21;
      SHAKE256: rate_lanes = 5'd17;
      default:  rate_lanes = 5'd17;
    endcase
  endfunction

  function automatic logic [7:0] mode_suffix(input keccak_mode mode);
    case (mode)
      SHAKE128, SHAKE256: mode_suffix = SHAKE_SUFFIX;
      SHA3_256, SHA3_512: mode_suffix = SHA3_SUFFIX;
      default:            mode_suffix = SHA3_SUFFIX;
    endcase
  endfunction

endpackage

// File: rtl/keccak_lane_padder.sv
// Combinational lane padder: keeps the first nbytes message bytes, inserts the
// suffix right after them, and sets the final pad bit on the rate's last lane.
module keccak_lane_padder
  import keccak_pkg::*;
(
  input  logic [63:0] lane,
  input  logic [3:0]  nbytes,
  input  logic [7:0]  suffix,
  input  logic        is_last_lane,
  output logic [63:0] padded
);

  // Byte-wise merge; nbytes == 8 means a full data lane with no suffix.
  always_comb begin
    padded = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) begin
        padded[b*8 +: 8] = lane[b*8 +: 8];
      end else if (4'(b) == nbytes) begin
        padded[b*8 +: 8] = suffix;
      end else begin
        padded[b*8 +: 8] = 8'h00;
      end
    end
    if (is_last_lane) begin
      padded[63:56] = padded[63:56] | PAD_LAST_BYTE;
    end else begin
      padded[63:56] = padded[63:56];
    end
  end

endmodule

// File: rtl/keccak_absorb_packer.sv
// Keccak absorb front-end: packs a byte-masked message stream into 64-bit rate
// lanes, appending the domain suffix and pad10*1 padding with block sequencing.
module keccak_absorb_packer
  import keccak_pkg::*;
#(
  parameter int DWIDTH         = 256,
  parameter int LANE_SIZE      = 64,
  parameter int LANE_IDX_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] mode_i,
  input  logic [DWIDTH-1:0]         s_tdata_i,
  input  logic [DWIDTH/8-1:0]       s_tkeep_i,
  input  logic                      s_tvalid_i,
  input  logic                      s_tlast_i,
  output logic                      s_tready_o,
  output logic [LANE_SIZE-1:0]      lane_data_o,
  output logic [LANE_IDX_WIDTH-1:0] lane_idx_o,
  output logic                      lane_valid_o,
  input  logic                      lane_ready_i,
  output logic                      block_last_o,
  output logic                      msg_last_o,
  output logic                      busy_o
);

  localparam int LANES = DWIDTH / LANE_SIZE;
  localparam int KB_W  = $clog2(DWIDTH / 8 + 1);
  localparam int J_W   = $clog2(LANES + 1);

  absorb_state               state_r;
  keccak_mode                mode_r;
  logic [DWIDTH-1:0]         beat_r;
  logic [KB_W-1:0]           kbytes_r;
  logic                      tlast_r;
  logic [J_W-1:0]            cur_j_r;
  logic [LANE_IDX_WIDTH-1:0] lane_cnt_r;

  logic [KB_W-1:0]           kb_in_s;
  logic                      kb_run_s;
  logic [LANE_IDX_WIDTH-1:0] last_idx_s;
  logic [7:0]                suffix_s;
  logic                      lane_acc_s;
  logic                      cur_is_pad_s;
  logic                      to_load_s;
  logic                      at_end_s;
  logic [DWIDTH-1:0]         src_beat_s;
  logic [KB_W-1:0]           src_kb_s;
  logic                      src_last_s;
  logic [J_W-1:0]            gen_j_s;
  logic                      zero_mode_s;
  logic                      gen_now_s;
  logic [LANE_SIZE-1:0]      lane_src_s;
  logic                      gen_pad_lane_s;
  logic [3:0]                gen_nbytes_s;
  logic                      gen_msg_last_s;
  logic [LANE_SIZE-1:0]      padded_s;

  assign last_idx_s   = LANE_IDX_WIDTH'(rate_lanes(mode_r) - 5'd1);
  assign suffix_s     = mode_suffix(mode_r);
  assign lane_acc_s   = lane_valid_o && lane_ready_i;
  assign cur_is_pad_s = tlast_r && (KB_W'(cur_j_r) == (kbytes_r >> 3'd3));
  assign to_load_s    = !tlast_r && (cur_j_r == J_W'(LANES - 1));
  assign at_end_s     = (lane_cnt_r == last_idx_s);

  // Valid byte count is the run of ones from keep bit 0; anything past the first gap is dropped.
  always_comb begin
    kb_in_s  = '0;
    kb_run_s = 1'b1;
    for (int i = 0; i < DWIDTH / 8; i++) begin
      if (kb_run_s && s_tkeep_i[i]) begin
        kb_in_s = kb_in_s + KB_W'(1);
      end else begin
        kb_run_s = 1'b0;
      end
    end
  end

  // Pick the source of the next lane and classify it as data, pad lane or trailing zero lane.
  always_comb begin
    src_beat_s  = beat_r;
    src_kb_s    = kbytes_r;
    src_last_s  = tlast_r;
    gen_j_s     = cur_j_r + J_W'(1);
    zero_mode_s = 1'b0;
    gen_now_s   = 1'b0;
    case (state_r)
      AB_LOAD: begin
        src_beat_s = s_tdata_i;
        src_kb_s   = kb_in_s;
        src_last_s = s_tlast_i;
        gen_j_s    = '0;
        gen_now_s  = s_tvalid_i && s_tready_o;
      end
      AB_EMIT: begin
        zero_mode_s = cur_is_pad_s;
        gen_now_s   = lane_acc_s && !msg_last_o && (cur_is_pad_s || !to_load_s);
      end
      AB_PAD: begin
        zero_mode_s = 1'b1;
        gen_now_s   = lane_acc_s && !msg_last_o;
      end
      default: begin
        gen_now_s = 1'b0;
      end
    endcase
    lane_src_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!zero_mode_s && (gen_j_s == J_W'(k))) begin
        lane_src_s = src_beat_s[k*LANE_SIZE +: LANE_SIZE];
      end else begin
        lane_src_s = lane_src_s;
      end
    end
    gen_pad_lane_s = !zero_mode_s && src_last_s && (KB_W'(gen_j_s) == (src_kb_s >> 3'd3));
    if (gen_pad_lane_s) begin
      gen_nbytes_s = {1'b0, src_kb_s[2:0]};
    end else begin
      gen_nbytes_s = 4'd8;
    end
    gen_msg_last_s = (gen_pad_lane_s || zero_mode_s) && at_end_s;
  end

  keccak_lane_padder u_padder (
    .lane         (lane_src_s),
    .nbytes       (gen_nbytes_s),
    .suffix       (suffix_s),
    .is_last_lane (gen_msg_last_s),
    .padded       (padded_s)
  );

  // Absorb sequencer: beat capture, state transitions and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= AB_IDLE;
      mode_r       <= SHA3_256;
      beat_r       <= '0;
      kbytes_r     <= '0;
      tlast_r      <= 1'b0;
      cur_j_r      <= '0;
      lane_cnt_r   <= '0;
      s_tready_o   <= 1'b0;
      lane_valid_o <= 1'b0;
      lane_data_o  <= '0;
      lane_idx_o   <= '0;
      block_last_o <= 1'b0;
      msg_last_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_r)
        AB_IDLE: begin
          if (start_i) begin
            state_r    <= AB_LOAD;
            mode_r     <= keccak_mode'(mode_i);
            lane_cnt_r <= '0;
            busy_o     <= 1'b1;
            s_tready_o <= 1'b1;
          end
        end
        AB_LOAD: begin
          if (s_tvalid_i && s_tready_o) begin
            beat_r     <= s_tdata_i;
            kbytes_r   <= kb_in_s;
            tlast_r    <= s_tlast_i;
            cur_j_r    <= '0;
            s_tready_o <= 1'b0;
            state_r    <= AB_EMIT;
          end
        end
        AB_EMIT: begin
          if (lane_acc_s) begin
            if (msg_last_o) begin
              state_r <= AB_DONE;
              busy_o  <= 1'b0;
            end else if (cur_is_pad_s) begin
              state_r <= AB_PAD;
            end else if (to_load_s) begin
              state_r    <= AB_LOAD;
              s_tready_o <= 1'b1;
            end else begin
              cur_j_r <= cur_j_r + J_W'(1);
            end
          end
        end
        AB_PAD: begin
          if (lane_acc_s && msg_last_o) begin
            state_r <= AB_DONE;
            busy_o  <= 1'b0;
          end
        end
        AB_DONE: begin
          state_r <= AB_IDLE;
        end
        default: begin
          state_r <= AB_IDLE;
        end
      endcase

      // The output slot refills on the same edge it drains, giving one lane per cycle.
      if (gen_now_s) begin
        lane_valid_o <= 1'b1;
        lane_data_o  <= padded_s;
        lane_idx_o   <= lane_cnt_r;
        block_last_o <= at_end_s;
        msg_last_o   <= gen_msg_last_s;
        lane_cnt_r   <= at_end_s ? '0 : lane_cnt_r + LANE_IDX_WIDTH'(1);
      end else if (lane_acc_s) begin
        lane_valid_o <= 1'b0;
        block_last_o <= 1'b0;
        msg_last_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_absorb_packer.sv
// Self-checking bench for keccak_absorb_packer: a byte-level padding model
// feeds a lane scoreboard, plus literal checks on known vectors.
module tb_keccak_absorb_packer;
  import keccak_pkg::*;

  localparam int DW = 256;
  localparam int BB = DW / 8;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        bl;
    logic        ml;
  } lane_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] s_tdata_i;
  logic [BB-1:0] s_tkeep_i;
  logic          s_tvalid_i;
  logic          s_tlast_i;
  logic          s_tready_o;
  logic [63:0]   lane_data_o;
  logic [4:0]    lane_idx_o;
  logic          lane_valid_o;
  logic          lane_ready_i = 1'b1;
  logic          block_last_o;
  logic          msg_last_o;
  logic          busy_o;

  always #5 clk = ~clk;

  keccak_absorb_packer #(.DWIDTH(DW), .LANE_SIZE(64), .LANE_IDX_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i), .s_tvalid_i(s_tvalid_i),
    .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o), .lane_data_o(lane_data_o),
    .lane_idx_o(lane_idx_o), .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i),
    .block_last_o(block_last_o), .msg_last_o(msg_last_o), .busy_o(busy_o)
  );

  lane_t       exp_q[$];
  lane_t       cur_e;
  logic [7:0]  msg_buf [0:255];
  logic [63:0] got_data [0:63];
  logic        got_bl [0:63];
  logic        got_ml [0:63];
  int          got_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  bit          rand_stall = 1'b0;
  bit          stalled = 1'b0;
  logic [63:0] hold_data;
  logic [4:0]  hold_idx;
  logic        hold_bl, hold_ml;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Padded message = msg || suffix || zeros, length a multiple of the rate, last byte |= 0x80.
  task automatic model_push(input keccak_mode m, input int len);
    int rl, rb, total;
    logic [7:0] sfx;
    logic [7:0] p[$];
    lane_t e;
    case (m)
      SHA3_256: rl = 17;
      SHA3_512: rl = 9;
      SHAKE128: rl = 21;
      default:  rl = 17;
    endcase
    sfx = (m == SHAKE128 || m == SHAKE256) ? 8'h1F : 8'h06;
    rb = rl * 8;
    total = ((len + 1 + rb - 1) / rb) * rb;
    for (int i = 0; i < total; i++) p.push_back(i < len ? msg_buf[i] : (i == len ? sfx : 8'h00));
    p[total-1] = p[total-1] | 8'h80;
    for (int n = 0; n < total / 8; n++) begin
      for (int b = 0; b < 8; b++) e.data[b*8 +: 8] = p[n*8+b];
      e.idx = 5'(n % rl);
      e.bl  = ((n % rl) == rl - 1);
      e.ml  = (n == total / 8 - 1);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: drives lane_ready_i, checks hold-under-stall and every accepted lane.
  always @(negedge clk) begin
    if (chk_en) begin
      if (stalled) begin
        check("hold_valid", 64'(lane_valid_o), 64'd1);
        check("hold_data", lane_data_o, hold_data);
        check("hold_idx", 64'(lane_idx_o), 64'(hold_idx));
        check("hold_flags", 64'({block_last_o, msg_last_o}), 64'({hold_bl, hold_ml}));
      end
      lane_ready_i = rand_stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (lane_valid_o && lane_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_lane: got lane idx %0d, expected no lane", lane_idx_o);
        end else begin
          cur_e = exp_q.pop_front();
          check("lane_data", lane_data_o, cur_e.data);
          check("lane_idx", 64'(lane_idx_o), 64'(cur_e.idx));
          check("block_last", 64'(block_last_o), 64'(cur_e.bl));
          check("msg_last", 64'(msg_last_o), 64'(cur_e.ml));
        end
        if (got_n < 64) begin
          got_data[got_n] = lane_data_o;
          got_bl[got_n]   = block_last_o;
          got_ml[got_n]   = msg_last_o;
        end
        got_n++;
      end
      stalled   = lane_valid_o && !lane_ready_i;
      hold_data = lane_data_o;
      hold_idx  = lane_idx_o;
      hold_bl   = block_last_o;
      hold_ml   = msg_last_o;
    end else begin
      lane_ready_i = 1'b1;
      stalled = 1'b0;
    end
  end

  task automatic fill_pattern(input int seed);
    for (int i = 0; i < 256; i++) msg_buf[i] = 8'(i * 7 + seed);
  endtask

  task automatic start_msg(input keccak_mode m);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Drive one beat; keep has a stray bit above the first gap that must be ignored.
  task automatic send_beat(input int base, input int kb, input bit last);
    logic [DW-1:0] d;
    logic [BB-1:0] k;
    int budget;
    for (int i = 0; i < BB; i++) begin
      if (i < kb) begin
        d[i*8 +: 8] = msg_buf[base + i];
        k[i] = 1'b1;
      end else begin
        d[i*8 +: 8] = 8'hA5;
        k[i] = (i == kb + 1);
      end
    end
    s_tdata_i = d; s_tkeep_i = k; s_tvalid_i = 1'b1; s_tlast_i = last;
    budget = 0;
    while (!s_tready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("beat_accept", 64'(s_tready_o), 64'd1);
    @(negedge clk);
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
  endtask

  task automatic send_msg(input keccak_mode m, input int len);
    int nbeats, budget;
    model_push(m, len);
    got_n = 0;
    start_msg(m);
    nbeats = (len == 0) ? 1 : (len + BB - 1) / BB;
    for (int b = 0; b < nbeats; b++)
      send_beat(b * BB, (b == nbeats - 1) ? len - b * BB : BB, b == nbeats - 1);
    budget = 0;
    while ((busy_o || exp_q.size() != 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("msg_done", 64'(busy_o), 64'd0);
    check("lanes_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_empty_sha3_256();
    check("empty_count", 64'(got_n), 64'd17);
    check("empty_lane0", got_data[0], 64'h0000000000000006);
    check("empty_lane8", got_data[8], 64'h0000000000000000);
    check("empty_lane16", got_data[16], 64'h8000000000000000);
    check("empty_flags16", 64'({got_bl[16], got_ml[16]}), 64'd3);
    check("empty_ml0", 64'(got_ml[0]), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 64'(s_tready_o), 64'd0);
    check({tag, "_valid"}, 64'(lane_valid_o), 64'd0);
    check({tag, "_data"}, lane_data_o, 64'd0);
    check({tag, "_idx"}, 64'(lane_idx_o), 64'd0);
    check({tag, "_bl"}, 64'(block_last_o), 64'd0);
    check({tag, "_ml"}, 64'(msg_last_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; mode_i = 2'd0;
    s_tdata_i = '0; s_tkeep_i = '0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    fill_pattern(1);
    send_msg(SHA3_256, 0);
    check_empty_sha3_256();

    msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    send_msg(SHAKE128, 3);
    check("abc_count", 64'(got_n), 64'd21);
    check("abc_lane0", got_data[0], 64'h000000001F636261);
    check("abc_lane20", got_data[20], 64'h8000000000000000);
    check("abc_flags20", 64'({got_bl[20], got_ml[20]}), 64'd3);

    fill_pattern(5);
    send_msg(SHA3_512, 71);
    check("s512_count", 64'(got_n), 64'd9);
    check("s512_byte7", 64'(got_data[8][63:56]), 64'h86);
    check("s512_flags8", 64'({got_bl[8], got_ml[8]}), 64'd3);

    fill_pattern(9);
    send_msg(SHA3_256, 136);
    check("blk_count", 64'(got_n), 64'd34);
    check("blk_flags16", 64'({got_bl[16], got_ml[16]}), 64'd2);
    check("blk_lane17", got_data[17], 64'h0000000000000006);
    check("blk_lane33", got_data[33], 64'h8000000000000000);
    check("blk_ml33", 64'(got_ml[33]), 64'd1);

    fill_pattern(13);
    rand_stall = 1'b1;
    send_msg(SHAKE256, 200);
    rand_stall = 1'b0;
    check("stall_count", 64'(got_n), 64'd34);
    check("stall_bl16", 64'(got_bl[16]), 64'd1);
    check("stall_ml33", 64'(got_ml[33]), 64'd1);

    chk_en = 1'b0;
    fill_pattern(17);
    start_msg(SHA3_256);
    send_beat(0, BB, 1'b0);
    check("valid_before_reset", 64'(lane_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    send_msg(SHA3_256, 0);
    check_empty_sha3_256();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
